mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 32 +++
 rtl/mem_access.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory stage and the data memory.
// The master side issues the request; the slave side returns read data
// and the completion strobe.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_be,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_be,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage of the pipeline plus the MEM/WB register.
// Decodes load/store opcodes, drives a req/ack data bus, stalls the
// upstream stages while an access is outstanding, and places byte/half
// lanes for stores and extracts/extends them for loads.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned word and
// halfword accesses (no bus request, addr_exc raised with the W outputs).
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instrM,
  input  logic [31:0]  ALUOutM,
  input  logic [31:0]  WriteDataM,
  input  logic [31:0]  pcplusM,
  mem_access_if.master bus,
  output logic         stallM,
  output logic [31:0]  instrW,
  output logic [31:0]  ALUOutW,
  output logic [31:0]  ReadDataW,
  output logic [31:0]  pcplusW
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic         addr_exc
`endif
);

  localparam logic [31:0] PCPLUS_RST = 32'h0000_3008;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Byte-enable pattern for a store of the given size at the given offset.
  function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b0001 << off;
    endcase
    return be;
  endfunction

  // Replicate the store datum across every lane it may land in, so the
  // byte enables alone pick the target lane.
  function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] wd);
    logic [31:0] v;
    case (sz)
      SZ_WORD: v = wd;
      SZ_HALF: v = {2{wd[15:0]}};
      default: v = {4{wd[7:0]}};
    endcase
    return v;
  endfunction

  // Select the addressed lane of the read word and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input size_t       sz,
                                               input logic        sgn,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        v;
    b_s = rd[{off, 3'b000} +: 8];
    h_s = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      SZ_WORD: v = rd;
      SZ_HALF: v = sgn ? {{16{h_s[15]}}, h_s} : {16'h0000, h_s};
      default: v = sgn ? {{24{b_s[7]}}, b_s} : {24'h00_0000, b_s};
    endcase
    return v;
  endfunction

  state_t      state_q, state_d;
  logic        is_load, is_store, is_mem, is_signed;
  size_t       acc_size;
  logic [1:0]  addr_off;
  logic        misaligned;
  logic        access;
  logic        req_c, stall_c, ack_v;

  logic [31:0] instrW_q, ALUOutW_q, ReadDataW_q, pcplusW_q;

  assign addr_off = ALUOutM[1:0];

  // Opcode decode: access direction, width and signedness.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    acc_size  = SZ_WORD;
    case (instrM[31:26])
      6'h23: begin is_load = 1'b1;  acc_size = SZ_WORD;                   end
      6'h21: begin is_load = 1'b1;  acc_size = SZ_HALF; is_signed = 1'b1; end
      6'h25: begin is_load = 1'b1;  acc_size = SZ_HALF;                   end
      6'h20: begin is_load = 1'b1;  acc_size = SZ_BYTE; is_signed = 1'b1; end
      6'h24: begin is_load = 1'b1;  acc_size = SZ_BYTE;                   end
      6'h2B: begin is_store = 1'b1; acc_size = SZ_WORD;                   end
      6'h29: begin is_store = 1'b1; acc_size = SZ_HALF;                   end
      6'h28: begin is_store = 1'b1; acc_size = SZ_BYTE;                   end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
  // Word accesses need both low address bits clear, halfwords bit 0 clear.
  always_comb begin
    misaligned = 1'b0;
    case (acc_size)
      SZ_WORD: misaligned = is_mem & (addr_off != 2'b00);
      SZ_HALF: misaligned = is_mem & addr_off[0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign access = is_mem & ~misaligned;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, bus request and stall; reset suppresses any request so an
  // abandoned access never reaches the bus again.
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          req_c = 1'b1;
          if (!bus.mem_ack) begin
            stall_c = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (bus.mem_ack) state_d = S_IDLE;
        else             stall_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      req_c   = 1'b0;
      stall_c = 1'b0;
      state_d = S_IDLE;
    end
  end

  assign ack_v = req_c & bus.mem_ack;

  // Bus request fields; held at zero whenever no request is being made.
  always_comb begin
    bus.mem_req   = req_c;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = 32'h0000_0000;
    bus.mem_wdata = 32'h0000_0000;
    if (req_c) begin
      bus.mem_addr = {ALUOutM[31:2], 2'b00};
      bus.mem_we   = is_store;
      if (is_store) begin
        bus.mem_be    = lane_be(acc_size, addr_off);
        bus.mem_wdata = store_lanes(acc_size, WriteDataM);
      end else begin
        bus.mem_be    = 4'b1111;
      end
    end
  end

  assign stallM = stall_c;

  // MEM/WB register: bubble while stalled, otherwise capture the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      instrW_q    <= 32'h0000_0000;
      ALUOutW_q   <= 32'h0000_0000;
      ReadDataW_q <= 32'h0000_0000;
      pcplusW_q   <= PCPLUS_RST;
    end else if (stall_c) begin
      instrW_q    <= 32'h0000_0000;
      ALUOutW_q   <= ALUOutM;
      ReadDataW_q <= 32'h0000_0000;
      pcplusW_q   <= pcplusM;
    end else begin
      instrW_q    <= instrM;
      ALUOutW_q   <= ALUOutM;
      ReadDataW_q <= (is_load && ack_v)
                     ? load_extract(acc_size, is_signed, addr_off, bus.mem_rdata)
                     : 32'h0000_0000;
      pcplusW_q   <= pcplusM;
    end
  end

  assign instrW    = instrW_q;
  assign ALUOutW   = ALUOutW_q;
  assign ReadDataW = ReadDataW_q;
  assign pcplusW   = pcplusW_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic addr_exc_q;

  // Misalignment flag travels with the instruction into the W stage.
  always_ff @(posedge clk) begin
    if (rst)          addr_exc_q <= 1'b0;
    else if (stall_c) addr_exc_q <= 1'b0;
    else              addr_exc_q <= misaligned;
  end

  assign addr_exc = addr_exc_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed load/store/reset vectors with literal
// expectations, plus a per-cycle comparison against a size/offset model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrM, ALUOutM, WriteDataM, pcplusM;
  logic        stallM;
  logic [31:0] instrW, ALUOutW, ReadDataW, pcplusW;
`ifdef MEM_ALIGN_CHECK_EN
  logic        addr_exc;
`endif

  int checks   = 0;
  int failures = 0;

  mem_access_if bus();

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .instrM     (instrM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .pcplusM    (pcplusM),
    .bus        (bus),
    .stallM     (stallM),
    .instrW     (instrW),
    .ALUOutW    (ALUOutW),
    .ReadDataW  (ReadDataW),
    .pcplusW    (pcplusW)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .addr_exc   (addr_exc)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD = 32'h0109_5020;
  localparam logic [31:0] I_LW  = {6'h23, 26'h025_1234};
  localparam logic [31:0] I_LH  = {6'h21, 26'h025_1234};
  localparam logic [31:0] I_LHU = {6'h25, 26'h025_1234};
  localparam logic [31:0] I_LB  = {6'h20, 26'h025_1234};
  localparam logic [31:0] I_LBU = {6'h24, 26'h025_1234};
  localparam logic [31:0] I_SW  = {6'h2B, 26'h025_1234};
  localparam logic [31:0] I_SH  = {6'h29, 26'h025_1234};
  localparam logic [31:0] I_SB  = {6'h28, 26'h025_1234};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int op_size(input logic [5:0] op);
    if (op == 6'h23 || op == 6'h2B)                  return 4;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29)   return 2;
    if (op == 6'h20 || op == 6'h24 || op == 6'h28)   return 1;
    return 0;
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == 6'h2B) || (op == 6'h29) || (op == 6'h28);
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21);
  endfunction

  function automatic bit op_misal(input int sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz > 1) && ((a % sz) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Offset of the naturally aligned container of the access inside the word.
  function automatic int lane_off(input int sz, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    return o - (o % sz);
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
    int v;
    v = ((1 << sz) - 1) << lane_off(sz, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
    if (sz == 1) return {24'h0, wd[7:0]}   * 32'h0101_0101;
    if (sz == 2) return {16'h0, wd[15:0]}  * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    v    = rd >> (8 * lane_off(sz, a));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = v & mask;
    if (sgn && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Expected W-stage contents for the edge that follows the current cycle.
  bit          have_prev = 1'b0;
  bit          exp_full;
  logic [31:0] e_instr, e_alu, e_rd, e_pc;
  bit          e_exc;

  always @(negedge clk) begin
    int          sz;
    bit          er, es, mis, st;
    logic [31:0] a;
    if (have_prev) begin
      chk("m_instrW", instrW, e_instr);
      chk("m_ReadDataW", ReadDataW, e_rd);
      if (exp_full) begin
        chk("m_ALUOutW", ALUOutW, e_alu);
        chk("m_pcplusW", pcplusW, e_pc);
      end
`ifdef MEM_ALIGN_CHECK_EN
      chk("m_addr_exc", {31'h0, addr_exc}, {31'h0, e_exc});
`endif
    end
    sz  = op_size(instrM[31:26]);
    a   = ALUOutM;
    st  = op_store(instrM[31:26]);
    mis = (sz != 0) && op_misal(sz, a);
    er  = !rst && (sz != 0) && !mis;
    es  = er && !bus.mem_ack;
    chk("m_mem_req", {31'h0, bus.mem_req}, {31'h0, er});
    chk("m_stallM", {31'h0, stallM}, {31'h0, es});
    if (er) begin
      chk("m_mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
      chk("m_mem_we", {31'h0, bus.mem_we}, {31'h0, st});
      chk("m_mem_be", {28'h0, bus.mem_be}, st ? {28'h0, m_be(sz, a)} : 32'hF);
      if (st) chk("m_mem_wdata", bus.mem_wdata, m_wdata(sz, WriteDataM));
    end
    if (!rst && instrM == 32'h0) begin
      chk("m_idle_bus", {bus.mem_we, bus.mem_be, 27'h0}, 32'h0);
      chk("m_idle_addr", bus.mem_addr | bus.mem_wdata, 32'h0);
    end
    if (rst) begin
      exp_full = 1'b1; e_instr = 32'h0; e_alu = 32'h0; e_rd = 32'h0;
      e_pc = 32'h0000_3008; e_exc = 1'b0;
    end else if (es) begin
      exp_full = 1'b0; e_instr = 32'h0; e_rd = 32'h0; e_exc = 1'b0;
    end else begin
      exp_full = 1'b1; e_instr = instrM; e_alu = ALUOutM; e_pc = pcplusM;
      e_rd  = (er && !st) ? m_load(sz, op_signed(instrM[31:26]), a, bus.mem_rdata) : 32'h0;
      e_exc = mis;
    end
    have_prev = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] rd, input logic ack);
    instrM        = ins;
    ALUOutM       = alu;
    WriteDataM    = wd;
    pcplusM       = alu ^ 32'h0000_0400;
    bus.mem_rdata = rd;
    bus.mem_ack   = ack;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick; tick;
    chk("rst_instrW", instrW, 32'h0);
    chk("rst_ALUOutW", ALUOutW, 32'h0);
    chk("rst_ReadDataW", ReadDataW, 32'h0);
    chk("rst_pcplusW", pcplusW, 32'h0000_3008);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    rst = 1'b0;

    // non-memory op
    drive(I_ADD, 32'h0000_0055, 32'h0, 32'h0, 1'b0); #1;
    chk("add_req", {31'h0, bus.mem_req}, 32'h0);
    chk("add_stall", {31'h0, stallM}, 32'h0);
    tick;
    chk("add_instrW", instrW, I_ADD);

    // lb at 0x1003, same-cycle ack
    drive(I_LB, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 1'b1); #1;
    chk("lb_be", {28'h0, bus.mem_be}, 32'hF);
    chk("lb_addr", bus.mem_addr, 32'h0000_1000);
    chk("lb_stall", {31'h0, stallM}, 32'h0);
    tick;
    chk("lb_rd", ReadDataW, 32'hFFFF_FF80);

    // sh at 0x2002, ack after three stall cycles
    drive(I_SH, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_stall", {31'h0, stallM}, 32'h1);
      chk("sh_be", {28'h0, bus.mem_be}, 32'hC);
      chk("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
      chk("sh_we", {31'h0, bus.mem_we}, 32'h1);
      tick;
      chk("sh_bubble", instrW, 32'h0);
    end
    bus.mem_ack = 1'b1; #1;
    chk("sh_ack_stall", {31'h0, stallM}, 32'h0);
    tick;
    chk("sh_instrW", instrW, I_SH);

    // lhu at 0x0002
    drive(I_LHU, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 1'b1); tick;
    chk("lhu_rd", ReadDataW, 32'h0000_9ABC);

    // lh at 0x0002, one wait cycle
    drive(I_LH, 32'h0000_0002, 32'h0, 32'h8001_0000, 1'b0); tick;
    chk("lh_bubble", instrW, 32'h0);
    bus.mem_ack = 1'b1; tick;
    chk("lh_rd", ReadDataW, 32'hFFFF_8001);

    // lbu at 0x0001
    drive(I_LBU, 32'h0000_0001, 32'h0, 32'h0000_F000, 1'b1); #1;
    chk("lbu_we", {31'h0, bus.mem_we}, 32'h0);
    tick;
    chk("lbu_rd", ReadDataW, 32'h0000_00F0);

    // sw at 0x0004
    drive(I_SW, 32'h0000_0004, 32'hDEAD_BEEF, 32'h5555_5555, 1'b1); #1;
    chk("sw_be", {28'h0, bus.mem_be}, 32'hF);
    chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick;
    chk("sw_rd", ReadDataW, 32'h0);

    // sb at 0x0006
    drive(I_SB, 32'h0000_0006, 32'h0000_0077, 32'h0, 1'b1); #1;
    chk("sb_be", {28'h0, bus.mem_be}, 32'h4);
    chk("sb_wdata", bus.mem_wdata, 32'h7777_7777);
    tick;

    // lw at 0x0008
    drive(I_LW, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b1); tick;
    chk("lw_rd", ReadDataW, 32'hCAFE_F00D);

    // reset while waiting
    drive(I_SW, 32'h0000_0010, 32'h1111_2222, 32'h0, 1'b0); tick;
    chk("wait_stall", {31'h0, stallM}, 32'h1);
    rst = 1'b1; #1;
    chk("rstw_req", {31'h0, bus.mem_req}, 32'h0);
    tick;
    chk("rstw_req2", {31'h0, bus.mem_req}, 32'h0);
    chk("rstw_pcplusW", pcplusW, 32'h0000_3008);
    chk("rstw_instrW", instrW, 32'h0);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0); tick;
    rst = 1'b0;
    drive(I_ADD, 32'h0000_0077, 32'h0, 32'h0, 1'b0); #1;
    chk("post_rst_stall", {31'h0, stallM}, 32'h0);
    tick;
    chk("post_rst_instrW", instrW, I_ADD);

    // lw at 0x0001
`ifdef MEM_ALIGN_CHECK_EN
    drive(I_LW, 32'h0000_0001, 32'h0, 32'h1122_3344, 1'b0); #1;
    chk("mis_req", {31'h0, bus.mem_req}, 32'h0);
    chk("mis_stall", {31'h0, stallM}, 32'h0);
    tick;
    chk("mis_exc", {31'h0, addr_exc}, 32'h1);
    chk("mis_rd", ReadDataW, 32'h0);
    chk("mis_instrW", instrW, I_LW);
    drive(I_ADD, 32'h0, 32'h0, 32'h0, 1'b0); tick;
    chk("mis_exc_clr", {31'h0, addr_exc}, 32'h0);
`else
    drive(I_LW, 32'h0000_0001, 32'h0, 32'h1122_3344, 1'b1); #1;
    chk("mis_req", {31'h0, bus.mem_req}, 32'h1);
    chk("mis_addr", bus.mem_addr, 32'h0);
    tick;
    chk("mis_rd", ReadDataW, 32'h1122_3344);
`endif

    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick; tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
